// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: frame FSM on kbclk falling edges, E0/F0 prefix
// resolution, and a held make code for the two-digit hex display.
module ps2_rx_ctrl #(
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdata,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       brk,
    output logic       ext,
    output logic       err,
    output logic [3:0] disp_hi,
    output logic [3:0] disp_lo
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [7:0]       code_q, code_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic             code_valid_q, code_valid_d;
    logic             err_q, err_d;
    logic [3:0]       disp_hi_q, disp_hi_d;
    logic [3:0]       disp_lo_q, disp_lo_d;
    logic             kb_q;
    logic             fall;
    logic             byte_done;

    assign fall = kb_q & ~kbclk;

    // Next-state: frame sequencing, timeout abort, prefix decode.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tcnt_d       = tcnt_q + CNT_W'(1);
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_d       = code_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        disp_hi_d    = disp_hi_q;
        disp_lo_d    = disp_lo_q;
        byte_done    = 1'b0;

        if (state_q == IDLE || fall) tcnt_d = '0;

        case (state_q)
            IDLE: begin
                // A high data line at a falling edge is a glitch, not a start bit.
                if (fall && !kbdata) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {kbdata, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = kbdata;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if ((^{shift_q, par_q}) && kbdata) begin
                        byte_done = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A falling edge on the timeout cycle keeps the frame alive.
        if (state_q != IDLE && !fall && tcnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d    = IDLE;
            tcnt_d     = '0;
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end

        if (byte_done) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                code_d       = shift_q;
                brk_d        = brk_pend_q;
                ext_d        = ext_pend_q;
                code_valid_d = 1'b1;
                ext_pend_d   = 1'b0;
                brk_pend_d   = 1'b0;
                if (!brk_pend_q) begin
                    disp_hi_d = shift_q[7:4];
                    disp_lo_d = shift_q[3:0];
                end
            end
        end
    end

    // State registers with synchronous reset; kbclk sample resets high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tcnt_q       <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            disp_hi_q    <= '0;
            disp_lo_q    <= '0;
            kb_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tcnt_q       <= tcnt_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_q       <= code_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
            disp_hi_q    <= disp_hi_d;
            disp_lo_q    <= disp_lo_d;
            kb_q         <= kbclk;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign brk        = brk_q;
    assign ext        = ext_q;
    assign err        = err_q;
    assign disp_hi    = disp_hi_q;
    assign disp_lo    = disp_lo_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: table of frames with expected events, a scoreboard
// queue popped by a monitor, plus timeout and mid-frame reset sequences.
module tb_ps2_rx_ctrl;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbclk = 1'b1;
    logic       kbdata = 1'b1;
    logic [7:0] code;
    logic       code_valid, brk, ext, err;
    logic [3:0] disp_hi, disp_lo;

    ps2_rx_ctrl #(.TIMEOUT(100), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .kbclk(kbclk), .kbdata(kbdata),
        .code(code), .code_valid(code_valid), .brk(brk), .ext(ext),
        .err(err), .disp_hi(disp_hi), .disp_lo(disp_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [3:0] dhi;
        logic [3:0] dlo;
    } exp_t;

    // kind: 0 = no event expected, 1 = code_valid, 2 = err
    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [3:0] dhi;
        logic [3:0] dlo;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        kbdata = b;
        kbclk  = 1'b0;
        tick(H);
        kbclk  = 1'b1;
        tick(H);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        kbdata = 1'b1;
    endtask

    task automatic push(input logic is_err, input logic [7:0] c, input logic b,
                        input logic e, input logic [3:0] hi, input logic [3:0] lo);
        exp_t x;
        x.is_err = is_err; x.code = c; x.brk = b; x.ext = e; x.dhi = hi; x.dlo = lo;
        sb.push_back(x);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid && err) begin
                errors++;
                checks++;
                $display("FAIL both_high: code_valid=%0b err=%0b expected not both", code_valid, err);
            end
            if (code_valid || err) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_event: code_valid=%0b err=%0b code=%0h expected none",
                             code_valid, err, code);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_is_err", 32'(err), 32'(e.is_err));
                    if (!e.is_err) begin
                        chk("code", 32'(code), 32'(e.code));
                        chk("brk", 32'(brk), 32'(e.brk));
                        chk("ext", 32'(ext), 32'(e.ext));
                    end
                    chk("disp_hi", 32'(disp_hi), 32'(e.dhi));
                    chk("disp_lo", 32'(disp_lo), 32'(e.dlo));
                end
            end
        end
    end

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 4'h1, 4'hC};
        tbl[1]  = '{8'hF0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b1, 1'b0, 4'h1, 4'hC};
        tbl[3]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[4]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b0, 1'b1, 4'h7, 4'h5};
        tbl[5]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[6]  = '{8'hF0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[7]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 4'h7, 4'h5};
        tbl[8]  = '{8'h1C, 1'b1, 1'b1, 2, 8'h00, 1'b0, 1'b0, 4'h7, 4'h5};
        tbl[9]  = '{8'h1C, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 4'h7, 4'h5};
        tbl[10] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 4'h1, 4'hC};
        tbl[11] = '{8'hF0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[12] = '{8'h1C, 1'b1, 1'b1, 2, 8'h00, 1'b0, 1'b0, 4'h1, 4'hC};
        tbl[13] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 4'h1, 4'hC};

        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_flags", 32'({code_valid, err, brk, ext}), 32'h0);
        chk("rst_disp", 32'({disp_hi, disp_lo}), 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].kind != 0)
                push(tbl[i].kind == 2, tbl[i].code, tbl[i].brk, tbl[i].ext, tbl[i].dhi, tbl[i].dlo);
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            tick(2);
            chk($sformatf("drained_%0d", i), 32'(sb.size()), 32'h0);
        end

        // Timeout: start + 4 data bits, then kbclk idles high.
        push(1'b1, 8'h00, 1'b0, 1'b0, 4'h1, 4'hC);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(120);
        chk("timeout_err_seen", 32'(sb.size()), 32'h0);
        push(1'b0, 8'h1C, 1'b0, 1'b0, 4'h1, 4'hC);
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(2);
        chk("after_timeout", 32'(sb.size()), 32'h0);

        // Reset mid-frame after an F0 prefix; no event may appear.
        send_frame(8'hF0, 1'b1, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_code", 32'(code), 32'h0);
        chk("mid_rst_flags", 32'({code_valid, err, brk, ext}), 32'h0);
        chk("mid_rst_disp", 32'({disp_hi, disp_lo}), 32'h0);
        tick(20);
        push(1'b0, 8'h1C, 1'b0, 1'b0, 4'h1, 4'hC);
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(4);
        chk("final_drained", 32'(sb.size()), 32'h0);
        chk("hold_code", 32'(code), 32'h1C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Sequences reception of PS/2 keyboard frames and turns the byte stream into qualified scan-code events.
- Input is the already-debounced keyboard clock and the raw keyboard data line. The block detects falling edges and runs the 11-bit frame state machine (start, 8 data, odd parity, stop).
- It resolves the E0 (extended) and F0 (break) prefixes and holds the last make code for the two-digit hex display path.
- It sits between the debouncer and the hex digit drivers in the keyboard subsystem.

Parameters:
TIMEOUT, 50000, clk cycles allowed between consecutive kbclk falling edges inside a frame before the frame is aborted.
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
kbclk  in  1  debounced PS/2 clock.
kbdata  in  1  PS/2 data line.
code  out  8  last completed scan code (prefix bytes excluded).
code_valid  out  1  one-cycle pulse; code/brk/ext valid in the same cycle.
brk  out  1  1 = code is a break (release) event.
ext  out  1  1 = code was preceded by E0.
err  out  1  one-cycle pulse on parity, stop-bit or timeout failure.
disp_hi  out  4  upper nibble of last make code.
disp_lo  out  4  lower nibble of last make code.

Behaviour:
- Reset:
  - On rst=1 at a clk edge: FSM goes to IDLE; bit counter, shift register, timeout counter, prefix flags and all outputs are set to 0.
  - Applies mid-frame; the partial frame is discarded with no err pulse.
- Edge detect:
  - kb_q is kbclk registered, reset value 1.
  - fall = kb_q & ~kbclk. All frame actions happen on cycles where fall=1.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with kbdata=0, go to DATA with bitcnt=0. On fall with kbdata=1, stay in IDLE (glitch ignored, no err).
  - DATA: on fall, shift kbdata in LSB-first and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch kbdata as the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. The frame is good iff (popcount(data)+parity) is odd and kbdata=1. Good frame raises internal byte_done; otherwise err pulses on the next cycle.
- Timeout:
  - Counter clears on every fall and while in IDLE; otherwise it increments.
  - On reaching TIMEOUT-1 outside IDLE: go to IDLE, pulse err, clear prefix flags.
  - If fall coincides with the timeout cycle, fall wins (no timeout).
- Decode on byte_done:
  - Byte 0xE0: set ext_pend; no output pulse.
  - Byte 0xF0: set brk_pend; no output pulse.
  - Any other byte: code = byte, brk = brk_pend, ext = ext_pend, code_valid=1 for one cycle, then clear both pend flags.
  - If brk_pend=0: disp_hi/disp_lo = byte[7:4]/byte[3:0], updated in the same cycle as code_valid. Break codes leave the display unchanged.
- Latency: code_valid and err are registered and asserted in the cycle immediately after the clk edge at which the stop-bit fall is sampled (1 cycle).
- Any err (parity, stop or timeout) also clears ext_pend and brk_pend.
- code, brk and ext hold their values between pulses.
- code_valid and err are never high in the same cycle.

Test Plan:
- Make code: frame for 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one code_valid with code=0x1C, brk=0, ext=0; disp_hi=1, disp_lo=C; err never asserted.
- Break: frames F0 (parity 1) then 1C (parity 0) -> exactly one code_valid, on the second frame, with code=0x1C, brk=1, ext=0; display stays at 1/C from the previous make.
- Extended: frames E0 (parity 0) then 75 (parity 0) -> code_valid with code=0x75, ext=1, brk=0; disp=7/5. Then frames E0, F0, 75 -> code_valid with brk=1, ext=1; display stays 7/5.
- Frame errors: 0x1C sent with parity 1 -> one err pulse, no code_valid. Valid parity but stop bit 0 -> err pulse. A following good 0x1C frame is accepted normally.
- Timeout (TIMEOUT=100): start bit plus 4 data bits, then kbclk held high for 100 cycles -> err pulse, FSM in IDLE. A following full 0x1C frame yields code_valid with code=0x1C.
- Reset mid-frame: after F0 then 5 bits of the next frame, assert rst for 1 cycle -> all outputs 0, no err. A fresh 1C frame then gives brk=0, proving brk_pend was cleared.
